// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------
// sha256_pkg : shared SHA-256 constants and transmitter state type (rev 1.0)
// ----------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

  localparam int SHA256_DIGEST_BYTES   = 32;
  localparam int SHA256_DIGEST_NIBBLES = 64;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic {TX_IDLE, TX_SEND} sha256_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_digest_tx_if.sv
// ----------------------------------------------------------------------
// sha256_digest_tx_if : valid/ready byte stream with last marker (rev 1.0)
// ----------------------------------------------------------------------
`default_nettype none

interface sha256_digest_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, input  tx_last, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/sha256_hex_encode.sv
// ----------------------------------------------------------------------
// sha256_hex_encode : nibble to lowercase ASCII hex character (rev 1.0)
// ----------------------------------------------------------------------
`default_nettype none

module sha256_hex_encode
  import sha256_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_digest_tx.sv
// ----------------------------------------------------------------------
// sha256_digest_tx : streams a captured digest as raw bytes or hex text (rev 1.0)
// ----------------------------------------------------------------------
`default_nettype none

module sha256_digest_tx
  import sha256_pkg::*;
#(
  parameter int unsigned APPEND_NL = 1
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [255:0]              hash_in,
  input  logic                      hash_valid_in,
  input  logic                      hex_mode,
  sha256_digest_tx_if.master        tx,
  output logic                      busy,
  output logic                      overrun
);

  localparam logic [6:0] RAW_LAST = 7'(SHA256_DIGEST_BYTES - 1);
  localparam logic [6:0] HEX_LAST = (APPEND_NL != 0) ? 7'(SHA256_DIGEST_NIBBLES)
                                                     : 7'(SHA256_DIGEST_NIBBLES - 1);

  sha256_tx_state_t state;
  sha256_tx_state_t state_nxt;

  logic [255:0] hold;
  logic [6:0]   idx;
  logic         hex_lat;

  logic         at_last;
  logic         xfer;
  logic         done;
  logic         cap;
  logic         drop;
  logic [4:0]   byte_sel;
  logic [5:0]   nib_sel;
  logic [3:0]   nibble;
  logic [7:0]   hex_char;

  assign at_last = (state == TX_SEND) && (idx == (hex_lat ? HEX_LAST : RAW_LAST));
  assign xfer    = (state == TX_SEND) && tx.tx_ready;
  assign done    = xfer && at_last;
  // A strobe landing on the final transfer is a legal back-to-back capture.
  assign cap     = hash_valid_in && enable && ((state == TX_IDLE) || done);
  assign drop    = hash_valid_in && (state == TX_SEND) && !cap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE: if (cap) state_nxt = TX_SEND;
      TX_SEND: if (done && !cap) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= '0;
      idx     <= '0;
      hex_lat <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (cap) begin
        hold    <= hash_in;
        hex_lat <= hex_mode;
        idx     <= '0;
      end else if (xfer) begin
        idx     <= idx + 7'd1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign byte_sel = 5'd31 - idx[4:0];
  assign nib_sel  = 6'd63 - idx[5:0];
  assign nibble   = hold[{nib_sel, 2'b00} +: 4];

  sha256_hex_encode u_hex_encode (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  // Output decode from registered state only
  always_comb begin
    tx.tx_valid = (state == TX_SEND);
    tx.tx_last  = at_last;
    busy        = (state == TX_SEND);
    tx.tx_data  = 8'h00;
    if (state == TX_SEND) begin
      if (hex_lat) begin
        tx.tx_data = idx[6] ? ASCII_LF : hex_char;
      end else begin
        tx.tx_data = hold[{byte_sel, 3'b000} +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_digest_tx.sv
// ----------------------------------------------------------------------
// tb_sha256_digest_tx : scoreboard bench for sha256_digest_tx (rev 1.0)
// ----------------------------------------------------------------------
`default_nettype none

module tb_sha256_digest_tx;

  localparam logic [255:0] D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [255:0] hash_in;
  logic         hash_valid_in;
  logic         hex_mode;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {last, data}
  logic [8:0] exp_q[$];

  sha256_digest_tx_if tx_if ();

  sha256_digest_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .hash_in       (hash_in),
    .hash_valid_in (hash_valid_in),
    .hex_mode      (hex_mode),
    .tx            (tx_if),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_digest(input logic [255:0] d, input bit hex);
    logic [3:0] n;
    if (!hex) begin
      for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), d[255 - 8*i -: 8]});
    end else begin
      for (int i = 0; i < 64; i++) begin
        n = d[255 - 4*i -: 4];
        exp_q.push_back({1'b0, (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n})});
      end
      exp_q.push_back({1'b1, 8'h0A});
    end
  endtask

  task automatic strobe(input logic [255:0] d, input bit hex, input bit push);
    @(posedge clk); #1;
    hash_in       = d;
    hex_mode      = hex;
    hash_valid_in = 1'b1;
    if (push) push_digest(d, hex);
  endtask

  task automatic run_stream(input int budget, input bit rand_ready, input bit gapless,
                            input int inj_at, input logic [255:0] inj_d, input bit inj_push,
                            input bit toggle_hex, input int ovr_from);
    bit         prev_stall = 1'b0;
    logic [7:0] pd = '0;
    logic       pl = 1'b0;
    logic [8:0] e;
    logic       exp_o;
    int         k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(posedge clk); #1;
      hash_valid_in = 1'b0;
      if (k == inj_at) begin
        hash_in       = inj_d;
        hex_mode      = 1'b0;
        hash_valid_in = 1'b1;
        if (inj_push) push_digest(inj_d, 1'b0);
      end
      if (toggle_hex) hex_mode = ~hex_mode;
      tx_if.tx_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ({tx_if.tx_valid, tx_if.tx_last, tx_if.tx_data} !== {1'b1, pl, pd}) begin
          n_fail++;
          $display("FAIL stall_hold k=%0d: got valid=%b last=%b data=%h, need valid=1 last=%b data=%h",
                   k, tx_if.tx_valid, tx_if.tx_last, tx_if.tx_data, pl, pd);
        end
      end
      if (gapless) begin
        n_checks++;
        if (tx_if.tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL throughput k=%0d: got tx_valid=%b, need 1", k, tx_if.tx_valid);
        end
      end
      exp_o = (ovr_from >= 0) && (k >= ovr_from);
      n_checks++;
      if (overrun !== exp_o) begin
        n_fail++;
        $display("FAIL overrun k=%0d: got %b, need %b", k, overrun, exp_o);
      end
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({tx_if.tx_last, tx_if.tx_data} !== e) begin
          n_fail++;
          $display("FAIL byte k=%0d: got last=%b data=%h, need last=%b data=%h",
                   k, tx_if.tx_last, tx_if.tx_data, e[8], e[7:0]);
        end
      end
      prev_stall = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready !== 1'b1);
      pd = tx_if.tx_data;
      pl = tx_if.tx_last;
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d bytes outstanding, need 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    hash_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, tx_if.tx_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after: got busy=%b valid=%b, need 0 0", busy, tx_if.tx_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; hash_in = '0; hash_valid_in = 1'b0;
    hex_mode = 1'b0; tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_if.tx_data, tx_if.tx_valid, tx_if.tx_last, busy, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h valid=%b last=%b busy=%b ovr=%b, need all 0",
               tx_if.tx_data, tx_if.tx_valid, tx_if.tx_last, busy, overrun);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_if.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%b, need 0", tx_if.tx_valid);
    end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0;
    strobe(D, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      hash_valid_in  = 1'b0;
      tx_if.tx_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({tx_if.tx_valid, overrun} !== 2'b00) begin
        n_fail++;
        $display("FAIL enable_gate k=%0d: got valid=%b ovr=%b, need 0 0", k, tx_if.tx_valid, overrun);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_raw();
    strobe(D, 1'b0, 1'b1);
    run_stream(40, 1'b0, 1'b1, -1, '0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_hex();
    strobe(D, 1'b1, 1'b1);
    run_stream(80, 1'b0, 1'b1, -1, '0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    strobe(D, 1'b1, 1'b1);
    run_stream(600, 1'b1, 1'b0, -1, '0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    strobe(D, 1'b0, 1'b1);
    run_stream(80, 1'b0, 1'b1, 31, '1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_overrun();
    strobe(D, 1'b0, 1'b1);
    run_stream(60, 1'b0, 1'b1, 10, '0, 1'b0, 1'b0, 11);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b, need 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    strobe(D, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      hash_valid_in  = 1'b0;
      tx_if.tx_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if ({tx_if.tx_valid, tx_if.tx_data} !== {1'b1, 8'h36}) begin
      n_fail++;
      $display("FAIL hex_byte5: got valid=%b data=%h, need 1 36", tx_if.tx_valid, tx_if.tx_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_if.tx_data, tx_if.tx_valid, tx_if.tx_last, busy, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h valid=%b last=%b busy=%b ovr=%b, need all 0",
               tx_if.tx_data, tx_if.tx_valid, tx_if.tx_last, busy, overrun);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_if.tx_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL no_resume k=%0d: got valid=%b busy=%b, need 0 0", k, tx_if.tx_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_gate();
    test_raw();
    test_hex();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
